alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//   Execute stage of the multi-cycle RISC core. Decodes the 6-bit opcode into a
//   2-bit ALU operation, runs the 32-bit ALU and produces zero and carry flags.
//   Also computes the branch target, the jump target and the branch decision.
//   All outputs are registered, giving 1-cycle latency into the MEM stage.
// PARAMETERS
//   WIDTH   32  datapath width; the rules below assume 32.
// PORTS
//   clock         in   1   rising-edge clock
//   reset         in   1   asynchronous, active-high; clears all output registers
//   in_valid      in   1   capture inputs this cycle
//   opcode        in   6   instruction opcode
//   op_a          in   32  operand 1 (Rs1 value)
//   op_b          in   32  operand 2 (Rs2 / ext. imm / Rd value, muxed upstream)
//   pc            in   32  PC of the instruction
//   imm           in   32  sign-extended immediate
//   offset        in   26  jump offset field
//   out_valid     out  1   registered copy of in_valid
//   alu_op        out  2   00 AND, 01 ADD, 10 SUB, 11 PASS_B
//   alu_result    out  32  ALU result
//   zero_flag     out  1   alu_result == 0
//   carry_flag    out  1   ALU carry (see below)
//   branch_taken  out  1   conditional branch resolved taken
//   bta           out  32  pc + imm
//   jump_target   out  32  {pc[31:26], offset}
//   illegal_op    out  1   opcode > 16
// BEHAVIOUR
//   - Interface: reset reset, asynchronous, active-high; clock clock.
//   - Reset value of every output is 0.
//   - On posedge clock with in_valid=1, all outputs load from the combinational
//     result. With in_valid=0, out_valid loads 0 and all other outputs hold.
//   - Opcode map:
//       0 AND, 3 ANDI                    -> 00
//       1 ADD, 4 ADDI, 5 LW, 6 LW.POI, 7 SW -> 01 (address add)
//       8 BGT, 9 BLT, 10 BEQ, 11 BNE     -> 10
//       12..16 and illegal               -> 11
//   - AND: result = a & b, carry = 0.
//   - ADD: {carry, result} = a + b (33-bit sum).
//   - SUB: {carry, result} = a + ~b + 1. carry = 1 means no borrow (a >= b unsigned).
//   - PASS_B: result = b, carry = 0.
//   - zero_flag = (result == 0) for every op.
//   - branch_taken, only for opcodes 8..11 (0 for all others):
//       BGT = !Z & C;  BLT = !C;  BEQ = Z;  BNE = !Z.
//   - bta = pc + imm, mod 2^32 (wraps; no flag). Computed for every opcode.
//   - jump_target is computed for every opcode.
//   - illegal_op = 1 when opcode >= 17; alu_op is then 11 and branch_taken is 0.
//   - Reset asserted mid-operation clears outputs immediately. The first edge
//     after reset deassertion behaves normally.
// CONFIGURATION
//   ALU_SIGNED_BRANCH_EN
//     defined: BGT = !Z & (N == V), BLT = (N != V), where
//       N = result[31] and V = signed overflow of the SUB.
//     undefined: unsigned carry-based compare as above.
//   ADD/SUB/flag outputs are identical in both builds.
// TESTING
//   - Reset: reset=1 asynchronously -> all outputs 0 without a clock edge.
//   - ADD: op=1, a=FFFFFFFF, b=1 -> result 0, Z=1, C=1, alu_op 01, next cycle.
//   - AND: op=0, a=F0F0F0F0, b=0FF0FFFF -> result 00F0F0F0, Z=0, C=0.
//   - BEQ: op=10, a=b=5, pc=100, imm=FFFFFFFC -> taken=1, bta=FC;
//     with BNE the same inputs give taken=0.
//   - BGT: op=8, a=1, b=FFFFFFFF -> taken=0 (unsigned);
//     taken=1 when ALU_SIGNED_BRANCH_EN is defined.
//   - J: op=12, pc=A0000000, offset=3FFFFFF -> jump_target A3FFFFFF, alu_op 11.
//     Then op=20 -> illegal_op=1. Then in_valid=0 -> out_valid=0, others held.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute stage: opcode decode, 32-bit ALU with zero/carry flags, branch and jump targets.
// Optional build macro ALU_SIGNED_BRANCH_EN selects signed BGT/BLT compares.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic [25:0]      offset,
  output logic             out_valid,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             branch_taken,
  output logic [WIDTH-1:0] bta,
  output logic [WIDTH-1:0] jump_target,
  output logic             illegal_op
);

  typedef enum logic [1:0] {
    ALU_AND  = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_PASS = 2'b11
  } alu_op_e;

  alu_op_e          alu_op_d;
  logic [WIDTH:0]   add_sum_s;
  logic [WIDTH:0]   sub_sum_s;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             zero_d;
  logic             taken_d;
  logic             illegal_d;
  logic [WIDTH-1:0] bta_d;
  logic [WIDTH-1:0] jump_d;

  logic             valid_q;
  logic [1:0]       alu_op_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;
  logic             taken_q;
  logic [WIDTH-1:0] bta_q;
  logic [WIDTH-1:0] jump_q;
  logic             illegal_q;

  // Opcode to ALU operation decode
  always_comb begin
    alu_op_d = ALU_PASS;
    case (opcode)
      6'd0, 6'd3:                   alu_op_d = ALU_AND;
      6'd1, 6'd4, 6'd5, 6'd6, 6'd7: alu_op_d = ALU_ADD;
      6'd8, 6'd9, 6'd10, 6'd11:     alu_op_d = ALU_SUB;
      default:                      alu_op_d = ALU_PASS;
    endcase
  end

  // ALU datapath and flags; SUB carry=1 means no borrow
  always_comb begin
    add_sum_s = {1'b0, op_a} + {1'b0, op_b};
    sub_sum_s = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
    result_d  = op_b;
    carry_d   = 1'b0;
    case (alu_op_d)
      ALU_AND: begin
        result_d = op_a & op_b;
        carry_d  = 1'b0;
      end
      ALU_ADD: begin
        result_d = add_sum_s[WIDTH-1:0];
        carry_d  = add_sum_s[WIDTH];
      end
      ALU_SUB: begin
        result_d = sub_sum_s[WIDTH-1:0];
        carry_d  = sub_sum_s[WIDTH];
      end
      default: begin
        result_d = op_b;
        carry_d  = 1'b0;
      end
    endcase
    zero_d    = (result_d == {WIDTH{1'b0}});
    illegal_d = (opcode > 6'd16);
    bta_d     = pc + imm;
    jump_d    = {pc[WIDTH-1:26], offset};
  end

`ifdef ALU_SIGNED_BRANCH_EN
  logic n_s;
  logic v_s;

  // Signed branch resolution from the SUB result's sign and overflow
  always_comb begin
    n_s     = sub_sum_s[WIDTH-1];
    v_s     = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_sum_s[WIDTH-1] != op_a[WIDTH-1]);
    taken_d = 1'b0;
    case (opcode)
      6'd8:    taken_d = !zero_d && (n_s == v_s);
      6'd9:    taken_d = (n_s != v_s);
      6'd10:   taken_d = zero_d;
      6'd11:   taken_d = !zero_d;
      default: taken_d = 1'b0;
    endcase
  end
`else
  // Unsigned branch resolution from the SUB carry
  always_comb begin
    taken_d = 1'b0;
    case (opcode)
      6'd8:    taken_d = !zero_d && carry_d;
      6'd9:    taken_d = !carry_d;
      6'd10:   taken_d = zero_d;
      6'd11:   taken_d = !zero_d;
      default: taken_d = 1'b0;
    endcase
  end
`endif

  // Output registers: load on in_valid, otherwise hold (valid drops)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      alu_op_q  <= 2'b00;
      result_q  <= {WIDTH{1'b0}};
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      taken_q   <= 1'b0;
      bta_q     <= {WIDTH{1'b0}};
      jump_q    <= {WIDTH{1'b0}};
      illegal_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        alu_op_q  <= alu_op_d;
        result_q  <= result_d;
        zero_q    <= zero_d;
        carry_q   <= carry_d;
        taken_q   <= taken_d;
        bta_q     <= bta_d;
        jump_q    <= jump_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign out_valid    = valid_q;
  assign alu_op       = alu_op_q;
  assign alu_result   = result_q;
  assign zero_flag    = zero_q;
  assign carry_flag   = carry_q;
  assign branch_taken = taken_q;
  assign bta          = bta_q;
  assign jump_target  = jump_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage with hand-computed expectations.
module tb_alu_exec_stage;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [5:0]  opcode;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [25:0] offset;
  logic        out_valid;
  logic [1:0]  alu_op;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic        carry_flag;
  logic        branch_taken;
  logic [31:0] bta;
  logic [31:0] jump_target;
  logic        illegal_op;

  int n_checks;
  int n_fail;

  alu_exec_stage #(.WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .opcode       (opcode),
    .op_a         (op_a),
    .op_b         (op_b),
    .pc           (pc),
    .imm          (imm),
    .offset       (offset),
    .out_valid    (out_valid),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .zero_flag    (zero_flag),
    .carry_flag   (carry_flag),
    .branch_taken (branch_taken),
    .bta          (bta),
    .jump_target  (jump_target),
    .illegal_op   (illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] p, input logic [31:0] im,
                      input logic [25:0] off);
    @(negedge clock);
    in_valid = v;
    opcode   = op;
    op_a     = a;
    op_b     = b;
    pc       = p;
    imm      = im;
    offset   = off;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".valid"},   {31'd0, out_valid},    32'd0);
    check_eq({tag, ".alu_op"},  {30'd0, alu_op},       32'd0);
    check_eq({tag, ".result"},  alu_result,            32'd0);
    check_eq({tag, ".z"},       {31'd0, zero_flag},    32'd0);
    check_eq({tag, ".c"},       {31'd0, carry_flag},   32'd0);
    check_eq({tag, ".taken"},   {31'd0, branch_taken}, 32'd0);
    check_eq({tag, ".bta"},     bta,                   32'd0);
    check_eq({tag, ".jump"},    jump_target,           32'd0);
    check_eq({tag, ".illegal"}, {31'd0, illegal_op},   32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    opcode   = 6'd0;
    op_a     = 32'd0;
    op_b     = 32'd0;
    pc       = 32'd0;
    imm      = 32'd0;
    offset   = 26'd0;
    #2;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // ADD overflow into carry
    step(1'b1, 6'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 32'd0, 26'd0);
    check_eq("add.valid",  {31'd0, out_valid},  32'd1);
    check_eq("add.result", alu_result,          32'h0000_0000);
    check_eq("add.z",      {31'd0, zero_flag},  32'd1);
    check_eq("add.c",      {31'd0, carry_flag}, 32'd1);
    check_eq("add.alu_op", {30'd0, alu_op},     32'd1);

    // AND
    step(1'b1, 6'd0, 32'hF0F0_F0F0, 32'h0FF0_FFFF, 32'd0, 32'd0, 26'd0);
    check_eq("and.result", alu_result,          32'h00F0_F0F0);
    check_eq("and.z",      {31'd0, zero_flag},  32'd0);
    check_eq("and.c",      {31'd0, carry_flag}, 32'd0);
    check_eq("and.alu_op", {30'd0, alu_op},     32'd0);

    // LW address add with bta wrap-around
    step(1'b1, 6'd5, 32'h0000_1000, 32'h0000_0020, 32'hFFFF_FFF0, 32'h0000_0020, 26'd0);
    check_eq("lw.result", alu_result,      32'h0000_1020);
    check_eq("lw.alu_op", {30'd0, alu_op}, 32'd1);
    check_eq("lw.bta",    bta,             32'h0000_0010);

    // BEQ and BNE on equal operands
    step(1'b1, 6'd10, 32'd5, 32'd5, 32'h0000_0100, 32'hFFFF_FFFC, 26'd0);
    check_eq("beq.taken",  {31'd0, branch_taken}, 32'd1);
    check_eq("beq.bta",    bta,                   32'h0000_00FC);
    check_eq("beq.alu_op", {30'd0, alu_op},       32'd2);
    check_eq("beq.z",      {31'd0, zero_flag},    32'd1);
    check_eq("beq.c",      {31'd0, carry_flag},   32'd1);
    step(1'b1, 6'd11, 32'd5, 32'd5, 32'h0000_0100, 32'hFFFF_FFFC, 26'd0);
    check_eq("bne.taken",  {31'd0, branch_taken}, 32'd0);

    // BGT / BLT with 1 vs FFFFFFFF: unsigned 1 < big, signed 1 > -1
    step(1'b1, 6'd8, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 26'd0);
    check_eq("bgt.result", alu_result,          32'h0000_0002);
    check_eq("bgt.c",      {31'd0, carry_flag}, 32'd0);
`ifdef ALU_SIGNED_BRANCH_EN
    check_eq("bgt.taken",  {31'd0, branch_taken}, 32'd1);
`else
    check_eq("bgt.taken",  {31'd0, branch_taken}, 32'd0);
`endif
    step(1'b1, 6'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 26'd0);
`ifdef ALU_SIGNED_BRANCH_EN
    check_eq("blt.taken",  {31'd0, branch_taken}, 32'd0);
`else
    check_eq("blt.taken",  {31'd0, branch_taken}, 32'd1);
`endif

    // J: pass-through and jump target
    step(1'b1, 6'd12, 32'h0000_0012, 32'h0000_0034, 32'hA000_0000, 32'h0000_0010, 26'h3FF_FFFF);
    check_eq("j.jump",    jump_target,          32'hA3FF_FFFF);
    check_eq("j.alu_op",  {30'd0, alu_op},      32'd3);
    check_eq("j.result",  alu_result,           32'h0000_0034);
    check_eq("j.bta",     bta,                  32'hA000_0010);
    check_eq("j.illegal", {31'd0, illegal_op},  32'd0);

    // Illegal boundary: 16 legal, 17 illegal
    step(1'b1, 6'd16, 32'd0, 32'd7, 32'hA000_0000, 32'd0, 26'h3FF_FFFF);
    check_eq("op16.illegal", {31'd0, illegal_op}, 32'd0);
    step(1'b1, 6'd17, 32'd0, 32'd7, 32'hA000_0000, 32'd0, 26'h3FF_FFFF);
    check_eq("op17.illegal", {31'd0, illegal_op}, 32'd1);
    step(1'b1, 6'd20, 32'd5, 32'd5, 32'hA000_0000, 32'd0, 26'h3FF_FFFF);
    check_eq("op20.illegal", {31'd0, illegal_op},   32'd1);
    check_eq("op20.alu_op",  {30'd0, alu_op},       32'd3);
    check_eq("op20.taken",   {31'd0, branch_taken}, 32'd0);

    // in_valid low: valid drops, everything else holds
    step(1'b0, 6'd1, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0, 26'd0);
    check_eq("hold.valid",   {31'd0, out_valid},  32'd0);
    check_eq("hold.illegal", {31'd0, illegal_op}, 32'd1);
    check_eq("hold.result",  alu_result,          32'h0000_0005);
    check_eq("hold.jump",    jump_target,         32'hA3FF_FFFF);
    check_eq("hold.alu_op",  {30'd0, alu_op},     32'd3);

    // Asynchronous reset between edges
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("areset");
    @(negedge clock);
    reset = 1'b0;

    // First edge after reset behaves normally
    step(1'b1, 6'd1, 32'd2, 32'd3, 32'd0, 32'd0, 26'd0);
    check_eq("post.valid",  {31'd0, out_valid},  32'd1);
    check_eq("post.result", alu_result,          32'd5);
    check_eq("post.c",      {31'd0, carry_flag}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
